product_code_stream_encoder: RTL and testbench

- Streaming, parametrised successor to the fixed 44-bit two-dimensional Hamming product encoder.
- Accepts data one row per beat and encodes each row with Hamming(2^ROW_R-1, 2^ROW_R-1-ROW_R).
- Buffers COL_K encoded rows, then emits the transposed columns one Hamming(2^COL_R-1, COL_K) codeword per beat.
- Sits between the framing source and the channel serializer; both sides use valid/ready handshakes.

---
 rtl/product_code_pkg.sv | 34 +++
 rtl/hamming_encoder_param.sv | 40 ++++
 rtl/product_code_stream_encoder.sv | 144 ++++++++++++++
 tb/tb_product_code_stream_encoder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/product_code_pkg.sv
// Shared definitions for the streaming Hamming product-code encoder:
// default code geometry, FSM states and Hamming layout helpers.
package product_code_pkg;

    localparam int unsigned ROW_N = 15;
    localparam int unsigned ROW_K = 11;
    localparam int unsigned COL_N = 7;
    localparam int unsigned COL_K = 4;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned ROW_IDX_W = idx_w(COL_K);
    localparam int unsigned COL_IDX_W = idx_w(ROW_N);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    // Bit p-1 set when codeword position p (1-based) is a parity position 2^k.
    function automatic logic [63:0] parity_mask(input int unsigned n);
        logic [63:0] mask;
        mask = '0;
        for (int unsigned k = 0; k < 6; k++) begin
            if ((32'd1 << k) <= n) begin
                mask[(32'd1 << k) - 1] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/hamming_encoder_param.sv
// Combinational Hamming(2^R-1, 2^R-1-R) encoder; codeword bit p-1 holds
// position p, parity at powers of two, data in the remaining positions.
module hamming_encoder_param
    import product_code_pkg::*;
#(
    parameter int unsigned R = 4
) (
    input  logic [(2**R)-R-2:0] data_in,
    output logic [(2**R)-2:0]   codeword_out
);

    localparam int unsigned N = (2**R) - 1;
    localparam logic [63:0] MASK = parity_mask(N);

    always_comb begin
        logic [N-1:0] cw;
        int unsigned  d;
        logic         par;
        cw  = '0;
        d   = 0;
        par = 1'b0;
        for (int unsigned p = 1; p <= N; p++) begin
            if (!MASK[p-1]) begin
                cw[p-1] = data_in[d];
                d++;
            end
        end
        for (int unsigned k = 0; k < R; k++) begin
            par = 1'b0;
            for (int unsigned p = 1; p <= N; p++) begin
                if (p[k] && !MASK[p-1]) begin
                    par = par ^ cw[p-1];
                end
            end
            cw[(32'd1 << k) - 1] = par;
        end
        codeword_out = cw;
    end

endmodule

// File: rtl/product_code_stream_encoder.sv
// Streaming 2-D Hamming product encoder: buffers a block of row codewords,
// then emits each transposed column as a column codeword, one per beat.
module product_code_stream_encoder
    import product_code_pkg::*;
#(
    parameter int unsigned ROW_R     = 4,
    parameter int unsigned COL_R     = 3,
    parameter int unsigned BLK_CNT_W = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [(2**ROW_R)-ROW_R-2:0]       s_data,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [(2**COL_R)-2:0]             m_data,
    output logic [idx_w((2**ROW_R)-1)-1:0]    m_col_idx,
    output logic                              m_last,
    output logic [BLK_CNT_W-1:0]              blk_cnt
);

    localparam int unsigned ROW_W  = (2**ROW_R) - 1;
    localparam int unsigned COL_W  = (2**COL_R) - 1;
    localparam int unsigned COL_DW = COL_W - COL_R;
    localparam int unsigned RC_W   = idx_w(COL_DW);
    localparam int unsigned CC_W   = idx_w(ROW_W);

    state_e               state_q, state_d;
    logic [RC_W-1:0]      row_cnt_q, row_cnt_d;
    logic [CC_W-1:0]      col_cnt_q, col_cnt_d;
    logic                 m_valid_q, m_valid_d;
    logic                 m_last_q, m_last_d;
    logic [COL_W-1:0]     m_data_q, m_data_d;
    logic [BLK_CNT_W-1:0] blk_cnt_q, blk_cnt_d;
    logic [ROW_W-1:0]     row_buf_q [COL_DW];
    logic [ROW_W-1:0]     row_buf_d [COL_DW];

    logic [ROW_W-1:0]     row_cw;
    logic [COL_DW-1:0]    col_data;
    logic [COL_W-1:0]     col_cw;

    hamming_encoder_param #(.R(ROW_R)) u_row_enc (
        .data_in      (s_data),
        .codeword_out (row_cw)
    );

    hamming_encoder_param #(.R(COL_R)) u_col_enc (
        .data_in      (col_data),
        .codeword_out (col_cw)
    );

    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        col_cnt_d = col_cnt_q;
        m_valid_d = m_valid_q;
        blk_cnt_d = blk_cnt_q;
        row_buf_d = row_buf_q;
        case (state_q)
            FILL: begin
                if (s_valid) begin
                    for (int unsigned r = 0; r < COL_DW; r++) begin
                        if (row_cnt_q == RC_W'(r)) begin
                            row_buf_d[r] = row_cw;
                        end
                    end
                    if (row_cnt_q == RC_W'(COL_DW - 1)) begin
                        row_cnt_d = '0;
                        col_cnt_d = '0;
                        m_valid_d = 1'b1;
                        state_d   = DRAIN;
                    end else begin
                        row_cnt_d = row_cnt_q + RC_W'(1);
                    end
                end
            end
            default: begin
                if (m_valid_q && m_ready) begin
                    if (col_cnt_q == CC_W'(ROW_W - 1)) begin
                        col_cnt_d = '0;
                        m_valid_d = 1'b0;
                        blk_cnt_d = blk_cnt_q + BLK_CNT_W'(1);
                        state_d   = FILL;
                    end else begin
                        col_cnt_d = col_cnt_q + CC_W'(1);
                    end
                end
            end
        endcase
        m_last_d = m_valid_d && (col_cnt_d == CC_W'(ROW_W - 1));
    end

    // Column is taken from next-state buffer/index so the first column is
    // already registered on the cycle after the final row is written.
    always_comb begin
        col_data = '0;
        for (int unsigned j = 0; j < ROW_W; j++) begin
            if (col_cnt_d == CC_W'(j)) begin
                for (int unsigned r = 0; r < COL_DW; r++) begin
                    col_data[COL_DW-1-r] = row_buf_d[r][ROW_W-1-j];
                end
            end
        end
    end

    always_comb begin
        m_data_d = m_valid_d ? col_cw : m_data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FILL;
            row_cnt_q <= '0;
            col_cnt_q <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
            blk_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            col_cnt_q <= col_cnt_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_data_q  <= m_data_d;
            blk_cnt_q <= blk_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            row_buf_q <= row_buf_d;
        end
    end

    assign s_ready   = (state_q == FILL);
    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_col_idx = col_cnt_q;
    assign m_last    = m_last_q;
    assign blk_cnt   = blk_cnt_q;

endmodule

// File: tb/tb_product_code_stream_encoder.sv
// Directed bench for product_code_stream_encoder: default 15x7 geometry plus
// a small 7x3 instance with a 2-bit block counter.
module tb_product_code_stream_encoder;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        s_valid;
    logic        s_ready;
    logic [10:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [6:0]  m_data;
    logic [3:0]  m_col_idx;
    logic        m_last;
    logic [15:0] blk_cnt;

    logic        s_valid2;
    logic        s_ready2;
    logic [3:0]  s_data2;
    logic        m_valid2;
    logic        m_ready2;
    logic [2:0]  m_data2;
    logic [2:0]  m_col_idx2;
    logic        m_last2;
    logic [1:0]  blk_cnt2;

    int          checks = 0;
    int          passes = 0;
    logic [6:0]  exp_cols [15];

    always #5 clk = ~clk;

    product_code_stream_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_col_idx (m_col_idx),
        .m_last    (m_last),
        .blk_cnt   (blk_cnt)
    );

    product_code_stream_encoder #(
        .ROW_R     (3),
        .COL_R     (2),
        .BLK_CNT_W (2)
    ) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid2),
        .s_ready   (s_ready2),
        .s_data    (s_data2),
        .m_valid   (m_valid2),
        .m_ready   (m_ready2),
        .m_data    (m_data2),
        .m_col_idx (m_col_idx2),
        .m_last    (m_last2),
        .blk_cnt   (blk_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Called at a negedge; returns at the negedge after the row is taken.
    task automatic send_row(input logic [10:0] d, input logic [14:0] exp_cw);
        s_valid = 1'b1;
        s_data  = d;
        #1;
        chk($sformatf("row_cw_%03h", d), dut.row_cw, exp_cw);
        @(negedge clk);
        s_valid = 1'b0;
        s_data  = '0;
    endtask

    task automatic drain_all(input string tag);
        m_ready = 1'b1;
        for (int j = 0; j < 15; j++) begin
            chk($sformatf("%s_valid%0d", tag, j), m_valid, 1'b1);
            chk($sformatf("%s_sready%0d", tag, j), s_ready, 1'b0);
            chk($sformatf("%s_idx%0d", tag, j), m_col_idx, j);
            chk($sformatf("%s_data%0d", tag, j), m_data, exp_cols[j]);
            chk($sformatf("%s_last%0d", tag, j), m_last, (j == 14));
            @(negedge clk);
        end
        m_ready = 1'b0;
        chk({tag, "_valid_end"}, m_valid, 1'b0);
        chk({tag, "_sready_end"}, s_ready, 1'b1);
    endtask

    initial begin
        int k;
        int cyc;

        rst_n    = 1'b0;
        s_valid  = 1'b1;
        s_data   = 11'h7FF;
        m_ready  = 1'b0;
        s_valid2 = 1'b0;
        s_data2  = '0;
        m_ready2 = 1'b0;

        // Reset held two edges while a row is offered
        repeat (2) @(negedge clk);
        chk("rst_sready", s_ready, 1'b1);
        chk("rst_mvalid", m_valid, 1'b0);
        chk("rst_blk", blk_cnt, 16'd0);
        chk("rst_mdata", m_data, 7'd0);
        chk("rst_idx", m_col_idx, 4'd0);
        chk("rst_last", m_last, 1'b0);
        chk("rst_mvalid2", m_valid2, 1'b0);
        rst_n   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        @(negedge clk);

        // All-ones block
        repeat (3) send_row(11'h7FF, 15'h7FFF);
        chk("ones_no_early_valid", m_valid, 1'b0);
        chk("ones_sready_fill", s_ready, 1'b1);
        send_row(11'h7FF, 15'h7FFF);
        for (int j = 0; j < 15; j++) exp_cols[j] = 7'h7F;
        drain_all("ones");
        chk("ones_blk", blk_cnt, 16'd1);

        // Single data bit in row 0
        send_row(11'h001, 15'h0007);
        repeat (3) send_row(11'h000, 15'h0000);
        for (int j = 0; j < 15; j++) exp_cols[j] = (j >= 12) ? 7'h4B : 7'h00;
        drain_all("single");
        chk("single_blk", blk_cnt, 16'd2);

        // Backpressure: rows 001, 002, 0, 0
        send_row(11'h001, 15'h0007);
        send_row(11'h002, 15'h0019);
        repeat (2) send_row(11'h000, 15'h0000);
        for (int j = 0; j < 15; j++) exp_cols[j] = 7'h00;
        exp_cols[10] = 7'h2A;
        exp_cols[11] = 7'h2A;
        exp_cols[12] = 7'h4B;
        exp_cols[13] = 7'h4B;
        exp_cols[14] = 7'h61;
        k   = 0;
        cyc = 0;
        while (k < 15 && cyc < 300) begin
            chk($sformatf("bp_valid_c%0d", cyc), m_valid, 1'b1);
            chk($sformatf("bp_sready_c%0d", cyc), s_ready, 1'b0);
            chk($sformatf("bp_idx_c%0d", cyc), m_col_idx, k);
            chk($sformatf("bp_data_c%0d", cyc), m_data, exp_cols[k]);
            chk($sformatf("bp_last_c%0d", cyc), m_last, (k == 14));
            m_ready = 1'($urandom_range(0, 1));
            if (m_ready) k++;
            @(negedge clk);
            cyc++;
        end
        chk("bp_completed_in_budget", (k == 15), 1'b1);
        m_ready = 1'b0;
        chk("bp_valid_end", m_valid, 1'b0);
        chk("bp_sready_end", s_ready, 1'b1);
        chk("bp_blk", blk_cnt, 16'd3);

        // Reset after two rows of a block
        repeat (2) send_row(11'h7FF, 15'h7FFF);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midfill_sready", s_ready, 1'b1);
        chk("midfill_mvalid", m_valid, 1'b0);
        chk("midfill_blk", blk_cnt, 16'd0);
        repeat (3) send_row(11'h7FF, 15'h7FFF);
        chk("midfill_no_early_valid", m_valid, 1'b0);
        send_row(11'h7FF, 15'h7FFF);
        for (int j = 0; j < 15; j++) exp_cols[j] = 7'h7F;
        drain_all("midfill");
        chk("midfill_blk_after", blk_cnt, 16'd1);

        // Reset after column 5 accepted
        repeat (4) send_row(11'h7FF, 15'h7FFF);
        m_ready = 1'b1;
        repeat (6) @(negedge clk);
        m_ready = 1'b0;
        chk("middrain_idx6", m_col_idx, 4'd6);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("middrain_mvalid", m_valid, 1'b0);
        chk("middrain_sready", s_ready, 1'b1);
        chk("middrain_idx", m_col_idx, 4'd0);
        chk("middrain_blk", blk_cnt, 16'd0);
        send_row(11'h001, 15'h0007);
        repeat (3) send_row(11'h000, 15'h0000);
        for (int j = 0; j < 15; j++) exp_cols[j] = (j >= 12) ? 7'h4B : 7'h00;
        drain_all("middrain");
        chk("middrain_blk_after", blk_cnt, 16'd1);

        // Small geometry: 1 row per block, 2-bit block counter
        for (int b = 0; b < 5; b++) begin
            s_valid2 = 1'b1;
            s_data2  = 4'hF;
            #1;
            chk($sformatf("p_row_cw_b%0d", b), dut2.row_cw, 7'h7F);
            @(negedge clk);
            s_valid2 = 1'b0;
            m_ready2 = 1'b1;
            for (int j = 0; j < 7; j++) begin
                chk($sformatf("p_valid_b%0d_%0d", b, j), m_valid2, 1'b1);
                chk($sformatf("p_sready_b%0d_%0d", b, j), s_ready2, 1'b0);
                chk($sformatf("p_data_b%0d_%0d", b, j), m_data2, 3'h7);
                chk($sformatf("p_idx_b%0d_%0d", b, j), m_col_idx2, j);
                chk($sformatf("p_last_b%0d_%0d", b, j), m_last2, (j == 6));
                @(negedge clk);
            end
            m_ready2 = 1'b0;
            chk($sformatf("p_valid_end_b%0d", b), m_valid2, 1'b0);
        end
        chk("p_blk_wrap", blk_cnt2, 2'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
